fp_mac_pe: RTL

Parametrised minifloat multiply-accumulate processing element for the systolic matrix-multiply array; successor to the fixed 8-bit MAC.
- Generic sign/exponent/fraction format.
- Two-stage registered multiply/accumulate pipeline with valid tagging.
- Accumulator clear, saturation with sticky overflow flag, underflow flush.
- Registered operand pass-through to neighbouring PEs.

---
 rtl/fp_mac_pkg.sv | 51 +++++
 rtl/fp_add_norm.sv | 102 ++++++++++
 rtl/fp_mac_pe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fp_mac_pkg.sv
// Shared constants and field helpers for the minifloat MAC processing element.
// Helpers take the field widths as arguments so parameter overrides stay consistent.
package fp_mac_pkg;

  localparam int unsigned EXP_W_DEF  = 3;
  localparam int unsigned FRAC_W_DEF = 4;
  localparam int unsigned WORD_MAX   = 32;

  localparam logic [WORD_MAX-1:0] CANON_ZERO = '0;

  // Exponent bias: 2^(exp_w-1)-1
  function automatic int unsigned bias_of(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  // Largest encodable exponent field
  function automatic int unsigned exp_max(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  // Max magnitude without sign: all exponent and fraction bits set
  function automatic logic [WORD_MAX-1:0] max_mag(input int unsigned exp_w,
                                                  input int unsigned frac_w);
    return (WORD_MAX'(1) << (exp_w + frac_w)) - WORD_MAX'(1);
  endfunction

  function automatic logic fld_sign(input logic [WORD_MAX-1:0] w,
                                    input int unsigned exp_w,
                                    input int unsigned frac_w);
    return 1'(w >> (exp_w + frac_w));
  endfunction

  function automatic logic [WORD_MAX-1:0] fld_exp(input logic [WORD_MAX-1:0] w,
                                                  input int unsigned exp_w,
                                                  input int unsigned frac_w);
    return (w >> frac_w) & ((WORD_MAX'(1) << exp_w) - WORD_MAX'(1));
  endfunction

  function automatic logic [WORD_MAX-1:0] fld_frac(input logic [WORD_MAX-1:0] w,
                                                   input int unsigned frac_w);
    return w & ((WORD_MAX'(1) << frac_w) - WORD_MAX'(1));
  endfunction

  // A zero exponent field encodes zero whatever the fraction and sign
  function automatic logic is_zero(input logic [WORD_MAX-1:0] w,
                                   input int unsigned exp_w,
                                   input int unsigned frac_w);
    return fld_exp(w, exp_w, frac_w) == '0;
  endfunction

endpackage

// File: rtl/fp_add_norm.sv
// Stage-2 combinational sign-magnitude adder: align, add/sub, renormalise,
// round (truncate, or round-to-nearest-even when FP_MAC_RNE_EN is defined), saturate.
module fp_add_norm
  import fp_mac_pkg::*;
#(
  parameter  int unsigned EXP_W  = EXP_W_DEF,
  parameter  int unsigned FRAC_W = FRAC_W_DEF,
  localparam int unsigned DATA_W = 1 + EXP_W + FRAC_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum_c,
  output logic              o_ovf_c
);

  localparam int unsigned SW = FRAC_W + 1;
  localparam int unsigned GW = FRAC_W + 3;
  localparam int unsigned MW = SW + GW;
  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX_S = EW'(exp_max(EXP_W));
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic [DATA_W-2:0]    MAG_MAX = (DATA_W-1)'(max_mag(EXP_W, FRAC_W));

  logic                 w_sa, w_sb, w_za, w_zb, w_a_big, w_s_big;
  logic [EXP_W-1:0]     w_ea, w_eb, w_e_big, w_e_small, w_shift;
  logic [FRAC_W-1:0]    w_fa, w_fb, w_frac;
  logic [MW-1:0]        w_m_big, w_m_small, w_mask, w_m_al, w_norm;
  logic [MW:0]          w_sum;
  logic signed [EW-1:0] w_exp;
`ifdef FP_MAC_RNE_EN
  logic                 w_guard, w_sticky;
  logic [FRAC_W:0]      w_rnd;
`endif

  assign w_sa = fld_sign(WORD_MAX'(i_a), EXP_W, FRAC_W);
  assign w_sb = fld_sign(WORD_MAX'(i_b), EXP_W, FRAC_W);
  assign w_ea = EXP_W'(fld_exp(WORD_MAX'(i_a), EXP_W, FRAC_W));
  assign w_eb = EXP_W'(fld_exp(WORD_MAX'(i_b), EXP_W, FRAC_W));
  assign w_fa = FRAC_W'(fld_frac(WORD_MAX'(i_a), FRAC_W));
  assign w_fb = FRAC_W'(fld_frac(WORD_MAX'(i_b), FRAC_W));
  assign w_za = is_zero(WORD_MAX'(i_a), EXP_W, FRAC_W);
  assign w_zb = is_zero(WORD_MAX'(i_b), EXP_W, FRAC_W);

  // Align, add, normalise, round and range-check the sum
  always_comb begin
    o_sum_c = DATA_W'(CANON_ZERO);
    o_ovf_c = 1'b0;
    w_a_big = ({w_ea, w_fa} >= {w_eb, w_fb});
    if (w_a_big) begin
      w_s_big   = w_sa;
      w_e_big   = w_ea;
      w_e_small = w_eb;
      w_m_big   = {1'b1, w_fa, {GW{1'b0}}};
      w_m_small = {1'b1, w_fb, {GW{1'b0}}};
    end else begin
      w_s_big   = w_sb;
      w_e_big   = w_eb;
      w_e_small = w_ea;
      w_m_big   = {1'b1, w_fb, {GW{1'b0}}};
      w_m_small = {1'b1, w_fa, {GW{1'b0}}};
    end
    w_shift = w_e_big - w_e_small;
    w_mask  = {MW{1'b1}} << w_shift;
    // Bits shifted out of the smaller operand collapse into a sticky LSB
    w_m_al  = (w_m_small >> w_shift) | MW'(|(w_m_small & ~w_mask));
    if (w_sa == w_sb) w_sum = {1'b0, w_m_big} + {1'b0, w_m_al};
    else              w_sum = {1'b0, w_m_big} - {1'b0, w_m_al};
    w_exp = $signed(EW'(w_e_big));
    if (w_sum[MW]) begin
      w_norm = w_sum[MW:1] | MW'(w_sum[0]);
      w_exp  = w_exp + ONE_S;
    end else begin
      w_norm = w_sum[MW-1:0];
      for (int i = 0; i < int'(GW); i++) begin
        if (!w_norm[MW-1]) begin
          w_norm = w_norm << 1;
          w_exp  = w_exp - ONE_S;
        end
      end
    end
    w_frac = w_norm[MW-2 -: FRAC_W];
`ifdef FP_MAC_RNE_EN
    w_guard  = w_norm[GW-1];
    w_sticky = |w_norm[GW-2:0];
    w_rnd    = {1'b0, w_frac};
    if (w_guard && (w_sticky || w_frac[0])) w_rnd = w_rnd + (FRAC_W+1)'(1);
    w_frac = w_rnd[FRAC_W-1:0];
    if (w_rnd[FRAC_W]) w_exp = w_exp + ONE_S;
`endif
    if (w_za && w_zb)          o_sum_c = DATA_W'(CANON_ZERO);
    else if (w_za)             o_sum_c = i_b;
    else if (w_zb)             o_sum_c = i_a;
    else if (w_norm == '0)     o_sum_c = DATA_W'(CANON_ZERO);
    else if (w_exp > EMAX_S) begin
      o_sum_c = {w_s_big, MAG_MAX};
      o_ovf_c = 1'b1;
    end
    else if (w_exp < ONE_S)    o_sum_c = DATA_W'(CANON_ZERO);
    else                       o_sum_c = {w_s_big, w_exp[EXP_W-1:0], w_frac};
  end

endmodule

// File: rtl/fp_mac_pe.sv
// Minifloat multiply-accumulate PE: stage 1 multiplies, stage 2 accumulates
// through fp_add_norm; operands are forwarded to neighbours one cycle later.
// Define FP_MAC_RNE_EN for round-to-nearest-even instead of truncation.
module fp_mac_pe
  import fp_mac_pkg::*;
#(
  parameter  int unsigned EXP_W  = EXP_W_DEF,
  parameter  int unsigned FRAC_W = FRAC_W_DEF,
  localparam int unsigned DATA_W = 1 + EXP_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              clr,
  input  logic [DATA_W-1:0] ain,
  input  logic [DATA_W-1:0] bin,
  output logic [DATA_W-1:0] apass,
  output logic [DATA_W-1:0] bpass,
  output logic              pass_valid,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              ovf
);

  localparam int unsigned SW = FRAC_W + 1;
  localparam int unsigned PW = 2 * SW;
  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX_S  = EW'(exp_max(EXP_W));
  localparam logic signed [EW-1:0] BIAS_S  = EW'(bias_of(EXP_W));
  localparam logic signed [EW-1:0] ONE_S   = EW'(1);
  localparam logic [DATA_W-2:0]    MAG_MAX = (DATA_W-1)'(max_mag(EXP_W, FRAC_W));

  logic [DATA_W-1:0] r_apass, r_bpass, r_s1_prod, r_acc;
  logic              r_pass_valid, r_s1_valid, r_s1_clr, r_s1_ovf, r_out_valid, r_ovf;

  logic                 w_sa, w_sb, w_za, w_zb, w_prod_ovf, w_add_ovf, w_unused_p;
  logic [EXP_W-1:0]     w_ea, w_eb;
  logic [FRAC_W-1:0]    w_fa, w_fb, w_p_frac;
  logic [PW-1:0]        w_p_raw, w_p_norm;
  logic signed [EW-1:0] w_p_exp;
  logic [DATA_W-1:0]    w_prod, w_sum;
`ifdef FP_MAC_RNE_EN
  logic                 w_guard, w_sticky;
  logic [FRAC_W:0]      w_rnd;
`endif

  assign w_sa = fld_sign(WORD_MAX'(ain), EXP_W, FRAC_W);
  assign w_sb = fld_sign(WORD_MAX'(bin), EXP_W, FRAC_W);
  assign w_ea = EXP_W'(fld_exp(WORD_MAX'(ain), EXP_W, FRAC_W));
  assign w_eb = EXP_W'(fld_exp(WORD_MAX'(bin), EXP_W, FRAC_W));
  assign w_fa = FRAC_W'(fld_frac(WORD_MAX'(ain), FRAC_W));
  assign w_fb = FRAC_W'(fld_frac(WORD_MAX'(bin), FRAC_W));
  assign w_za = is_zero(WORD_MAX'(ain), EXP_W, FRAC_W);
  assign w_zb = is_zero(WORD_MAX'(bin), EXP_W, FRAC_W);

  // Stage-1 multiply: significand product, one-step normalise, round, range-check
  always_comb begin
    w_prod     = DATA_W'(CANON_ZERO);
    w_prod_ovf = 1'b0;
    w_p_raw    = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});
    w_p_exp    = $signed(EW'(w_ea)) + $signed(EW'(w_eb)) - BIAS_S;
    if (w_p_raw[PW-1]) begin
      w_p_norm = w_p_raw;
      w_p_exp  = w_p_exp + ONE_S;
    end else begin
      w_p_norm = w_p_raw << 1;
    end
    w_p_frac = w_p_norm[PW-2 -: FRAC_W];
`ifdef FP_MAC_RNE_EN
    w_guard  = w_p_norm[PW-2-FRAC_W];
    w_sticky = |w_p_norm[PW-3-FRAC_W:0];
    w_rnd    = {1'b0, w_p_frac};
    if (w_guard && (w_sticky || w_p_frac[0])) w_rnd = w_rnd + (FRAC_W+1)'(1);
    w_p_frac = w_rnd[FRAC_W-1:0];
    if (w_rnd[FRAC_W]) w_p_exp = w_p_exp + ONE_S;
`endif
    if (w_za || w_zb)          w_prod = DATA_W'(CANON_ZERO);
    else if (w_p_exp > EMAX_S) begin
      w_prod     = {w_sa ^ w_sb, MAG_MAX};
      w_prod_ovf = 1'b1;
    end
    else if (w_p_exp < ONE_S)  w_prod = DATA_W'(CANON_ZERO);
    else                       w_prod = {w_sa ^ w_sb, w_p_exp[EXP_W-1:0], w_p_frac};
  end

  // The leading one, and under truncation the dropped tail, are not needed
`ifdef FP_MAC_RNE_EN
  assign w_unused_p = w_p_norm[PW-1];
`else
  assign w_unused_p = ^{w_p_norm[PW-1], w_p_norm[PW-3-FRAC_W:0]};
`endif

  fp_add_norm #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_add (
    .i_a     (r_acc),
    .i_b     (r_s1_prod),
    .o_sum_c (w_sum),
    .o_ovf_c (w_add_ovf)
  );

  // Pass-through, stage-1 product register and stage-2 accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_apass      <= '0;
      r_bpass      <= '0;
      r_pass_valid <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_clr     <= 1'b0;
      r_s1_prod    <= '0;
      r_s1_ovf     <= 1'b0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_apass      <= ain;
      r_bpass      <= bin;
      r_pass_valid <= in_valid;
      r_s1_valid   <= in_valid;
      r_s1_clr     <= clr;
      r_s1_prod    <= w_prod;
      r_s1_ovf     <= w_prod_ovf;
      r_out_valid  <= r_s1_valid;
      if (r_s1_valid) begin
        if (r_s1_clr) begin
          r_acc <= r_s1_prod;
          r_ovf <= r_ovf | r_s1_ovf;
        end else begin
          r_acc <= w_sum;
          r_ovf <= r_ovf | r_s1_ovf | w_add_ovf;
        end
      end
    end
  end

  assign apass      = r_apass;
  assign bpass      = r_bpass;
  assign pass_valid = r_pass_valid;
  assign out        = r_acc;
  assign out_valid  = r_out_valid;
  assign ovf        = r_ovf;

endmodule
